// File: rtl/random_log_spawner.sv
// random_log_spawner
//   Walks the static start-offset table one entry per spawn and turns each
//   9-bit X/Y offset into an absolute 11-bit spawn position. Each position is
//   offered to the log object manager over a valid/ready handshake. Spawns
//   are spaced by a programmable number of startOfFrame ticks.
//
// Ports
//   clk_i            system clock, rising edge
//   reset_i          synchronous active-high reset
//   start_i          pulse: begin a sequence at entry 0 (ignored unless idle)
//   stop_i           pulse: abort the sequence, drop any pending spawn
//   startOfFrame_i   one-cycle frame tick, counted only while waiting the gap
//   start_offsetX_i  table X offsets, sampled only in LOAD
//   start_offsetY_i  table Y offsets, sampled only in LOAD
//   spawn_ready_i    consumer accepts the offered spawn
//   spawn_valid_o    spawn_x_o/spawn_y_o/spawn_id_o are valid
//   spawn_x_o        absolute X (BASE_X + offset, mod 2048)
//   spawn_y_o        absolute Y (BASE_Y + offset, mod 2048)
//   spawn_id_o       table index of the offered spawn
//   busy_o           high in every state except IDLE
//   done_o           one-cycle pulse after the last entry is accepted (LOOP=0)
//
// State table
//   state    | meaning
//   IDLE     | no sequence running, waiting for start
//   LOAD     | one cycle: register position/id for the current index
//   OFFER    | spawn_valid high, outputs held until the handshake
//   WAIT_GAP | counting startOfFrame ticks before the next LOAD

module random_log_spawner #(
  parameter int unsigned NUM_ENTRIES = 100,
  parameter int unsigned GAP_FRAMES  = 8,
  parameter logic [10:0] BASE_X      = 11'd0,
  parameter logic [10:0] BASE_Y      = 11'd0,
  parameter bit          LOOP        = 1'b1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic        startOfFrame_i,
  input  logic [8:0]  start_offsetX_i [99:0],
  input  logic [8:0]  start_offsetY_i [99:0],
  input  logic        spawn_ready_i,
  output logic        spawn_valid_o,
  output logic [10:0] spawn_x_o,
  output logic [10:0] spawn_y_o,
  output logic [6:0]  spawn_id_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int GAP_W = (GAP_FRAMES < 2) ? 1 : $clog2(GAP_FRAMES + 1);
  localparam logic [6:0] LAST_IDX = 7'(NUM_ENTRIES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    OFFER    = 2'd2,
    WAIT_GAP = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [6:0]         idx_q, idx_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               valid_q, valid_d;
  logic [10:0]        x_q, x_d;
  logic [10:0]        y_q, y_d;
  logic [6:0]         id_q, id_d;
  logic               done_q, done_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      valid_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      id_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      valid_q <= valid_d;
      x_q     <= x_d;
      y_q     <= y_d;
      id_q    <= id_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    valid_d = valid_q;
    x_d     = x_q;
    y_d     = y_q;
    id_d    = id_q;
    done_d  = 1'b0;

    if (stop_i) begin
      // A handshake in this same cycle still counts for the consumer, but
      // nothing further is spawned.
      state_d = IDLE;
      valid_d = 1'b0;
      gap_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d = LOAD;
            idx_d   = '0;
          end
        end

        LOAD: begin
          // 11-bit add wraps modulo 2048 by construction.
          x_d     = BASE_X + {2'b00, start_offsetX_i[idx_q]};
          y_d     = BASE_Y + {2'b00, start_offsetY_i[idx_q]};
          id_d    = idx_q;
          valid_d = 1'b1;
          state_d = OFFER;
        end

        OFFER: begin
          if (spawn_ready_i) begin
            valid_d = 1'b0;
            if (idx_q == LAST_IDX && !LOOP) begin
              done_d  = 1'b1;
              idx_d   = '0;
              state_d = IDLE;
            end else begin
              idx_d = (idx_q == LAST_IDX) ? 7'd0 : idx_q + 7'd1;
              if (GAP_FRAMES == 0) begin
                state_d = LOAD;
              end else begin
                // Down-counter reloaded on every entry into WAIT_GAP.
                gap_d   = GAP_W'(GAP_FRAMES);
                state_d = WAIT_GAP;
              end
            end
          end
        end

        WAIT_GAP: begin
          if (startOfFrame_i) begin
            if (gap_q == GAP_W'(1)) begin
              gap_d   = '0;
              state_d = LOAD;
            end else begin
              gap_d = gap_q - GAP_W'(1);
            end
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign spawn_valid_o = valid_q;
  assign spawn_x_o     = x_q;
  assign spawn_y_o     = y_q;
  assign spawn_id_o    = id_q;
  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;

endmodule

// File: tb/tb_random_log_spawner.sv
// Testbench for random_log_spawner.
//   Three instances with different parameter sets:
//     k=0: NUM=4, GAP=0, LOOP=0   basic walk, backpressure, stop, reset in OFFER
//     k=1: NUM=4, GAP=3, LOOP=0   frame gap timing, reset in WAIT_GAP
//     k=2: NUM=2, GAP=0, LOOP=1, BASE_X=2040   wrap of index and of X
//   A cycle-level model derived from the behavioural rules runs beside the
//   DUTs and is compared every cycle; directed literal checks pin the model.

module tb_random_log_spawner;

  logic clk;
  logic [2:0] rst, st, sp, sof, rdy;
  logic [2:0] vld, bsy, dn;
  logic [2:0][10:0] sx, sy;
  logic [2:0][6:0]  sid;

  logic [8:0] tx_ab [99:0];
  logic [8:0] ty_ab [99:0];
  logic [8:0] tx_c  [99:0];

  int errors = 0;
  int checks = 0;
  bit started = 0;

  localparam int NUM [3] = '{4, 4, 2};
  localparam int GAP [3] = '{0, 3, 0};
  localparam int LP  [3] = '{0, 0, 1};
  localparam int BX  [3] = '{0, 0, 2040};
  localparam int BY  [3] = '{0, 0, 0};

  random_log_spawner #(.NUM_ENTRIES(4), .GAP_FRAMES(0), .BASE_X(11'd0),
                       .BASE_Y(11'd0), .LOOP(1'b0)) dut_a (
    .clk_i(clk), .reset_i(rst[0]), .start_i(st[0]), .stop_i(sp[0]),
    .startOfFrame_i(sof[0]), .start_offsetX_i(tx_ab), .start_offsetY_i(ty_ab),
    .spawn_ready_i(rdy[0]), .spawn_valid_o(vld[0]), .spawn_x_o(sx[0]),
    .spawn_y_o(sy[0]), .spawn_id_o(sid[0]), .busy_o(bsy[0]), .done_o(dn[0]));

  random_log_spawner #(.NUM_ENTRIES(4), .GAP_FRAMES(3), .BASE_X(11'd0),
                       .BASE_Y(11'd0), .LOOP(1'b0)) dut_b (
    .clk_i(clk), .reset_i(rst[1]), .start_i(st[1]), .stop_i(sp[1]),
    .startOfFrame_i(sof[1]), .start_offsetX_i(tx_ab), .start_offsetY_i(ty_ab),
    .spawn_ready_i(rdy[1]), .spawn_valid_o(vld[1]), .spawn_x_o(sx[1]),
    .spawn_y_o(sy[1]), .spawn_id_o(sid[1]), .busy_o(bsy[1]), .done_o(dn[1]));

  random_log_spawner #(.NUM_ENTRIES(2), .GAP_FRAMES(0), .BASE_X(11'd2040),
                       .BASE_Y(11'd0), .LOOP(1'b1)) dut_c (
    .clk_i(clk), .reset_i(rst[2]), .start_i(st[2]), .stop_i(sp[2]),
    .startOfFrame_i(sof[2]), .start_offsetX_i(tx_c), .start_offsetY_i(ty_ab),
    .spawn_ready_i(rdy[2]), .spawn_valid_o(vld[2]), .spawn_x_o(sx[2]),
    .spawn_y_o(sy[2]), .spawn_id_o(sid[2]), .busy_o(bsy[2]), .done_o(dn[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  typedef struct {
    bit busy, valid, done, loading, waiting;
    int idx, frames, x, y, id;
  } mdl_t;

  mdl_t m [3];

  function automatic int tab_x(int k, int i);
    return (k == 2) ? int'(tx_c[i]) : int'(tx_ab[i]);
  endfunction

  function automatic mdl_t step(mdl_t s, int k);
    mdl_t n;
    n = s;
    n.done = 0;
    if (rst[k]) begin
      n = '{default: 0};
    end else if (sp[k]) begin
      n.busy = 0; n.valid = 0; n.loading = 0; n.waiting = 0; n.frames = 0;
    end else if (!s.busy) begin
      if (st[k]) begin
        n.busy = 1; n.loading = 1; n.idx = 0;
      end
    end else if (s.loading) begin
      n.loading = 0;
      n.valid = 1;
      n.id = s.idx;
      n.x = (BX[k] + tab_x(k, s.idx)) % 2048;
      n.y = (BY[k] + int'(ty_ab[s.idx])) % 2048;
    end else if (s.valid) begin
      if (rdy[k]) begin
        n.valid = 0;
        if (s.idx == NUM[k] - 1 && LP[k] == 0) begin
          n.done = 1; n.busy = 0;
        end else begin
          n.idx = (s.idx + 1) % NUM[k];
          if (GAP[k] == 0) n.loading = 1;
          else begin n.waiting = 1; n.frames = 0; end
        end
      end
    end else if (s.waiting) begin
      if (sof[k]) begin
        n.frames = s.frames + 1;
        if (n.frames == GAP[k]) begin n.waiting = 0; n.loading = 1; end
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) m[k] = step(m[k], k);
    started = 1;
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("mdl%0d busy", k), int'(bsy[k]), int'(m[k].busy));
        chk($sformatf("mdl%0d valid", k), int'(vld[k]), int'(m[k].valid));
        chk($sformatf("mdl%0d done", k), int'(dn[k]), int'(m[k].done));
        if (m[k].valid) begin
          chk($sformatf("mdl%0d x", k), int'(sx[k]), m[k].x);
          chk($sformatf("mdl%0d y", k), int'(sy[k]), m[k].y);
          chk($sformatf("mdl%0d id", k), int'(sid[k]), m[k].id);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_valid(int k);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!vld[k] && n < 200);
    if (!vld[k]) chk($sformatf("timeout valid k%0d", k), 0, 1);
  endtask

  task automatic wait_done(int k);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!dn[k] && n < 200);
    if (!dn[k]) chk($sformatf("timeout done k%0d", k), 0, 1);
  endtask

  task automatic pulse_start(int k);
    st[k] = 1'b1;
    tick();
    st[k] = 1'b0;
  endtask

  task automatic chk_spawn(string name, int k, int x, int y, int id);
    chk({name, " valid"}, int'(vld[k]), 1);
    chk({name, " x"}, int'(sx[k]), x);
    chk({name, " y"}, int'(sy[k]), y);
    chk({name, " id"}, int'(sid[k]), id);
  endtask

  task automatic chk_reset_outs(string name, int k);
    chk({name, " valid"}, int'(vld[k]), 0);
    chk({name, " busy"}, int'(bsy[k]), 0);
    chk({name, " done"}, int'(dn[k]), 0);
    chk({name, " x"}, int'(sx[k]), 0);
    chk({name, " y"}, int'(sy[k]), 0);
    chk({name, " id"}, int'(sid[k]), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    for (int i = 0; i < 100; i++) begin
      tx_ab[i] = 9'(i);
      ty_ab[i] = 9'(2 * i);
      tx_c[i]  = 9'(i);
    end
    tx_c[1] = 9'd9;
    rst = 3'b111; st = '0; sp = '0; sof = '0; rdy = '0;
    repeat (3) tick();
    for (int k = 0; k < 3; k++) chk_reset_outs($sformatf("reset k%0d", k), k);
    rst = '0;
    tick();

    // ---- k=0: basic walk, back-to-back spawns ----
    rdy[0] = 1'b1;
    pulse_start(0);
    chk("a load busy", int'(bsy[0]), 1);
    chk("a load valid", int'(vld[0]), 0);
    for (int i = 0; i < 4; i++) begin
      wait_valid(0);
      chk_spawn($sformatf("a spawn%0d", i), 0, i, 2 * i, i);
      tick();
      chk($sformatf("a gap%0d valid", i), int'(vld[0]), 0);
      if (i == 3) begin
        chk("a done pulse", int'(dn[0]), 1);
        chk("a done busy", int'(bsy[0]), 0);
      end
    end
    tick();
    chk("a done cleared", int'(dn[0]), 0);

    // ---- k=0: backpressure at id 1, start while busy ignored ----
    pulse_start(0);
    wait_valid(0);
    chk_spawn("bp id0", 0, 0, 0, 0);
    tick();
    rdy[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk_spawn($sformatf("bp hold%0d", c), 0, 1, 2, 1);
      st[0] = (c == 2);
    end
    st[0] = 1'b0;
    rdy[0] = 1'b1;
    tick();
    chk("bp accepted once", int'(vld[0]), 0);
    wait_valid(0);
    chk_spawn("bp next", 0, 2, 4, 2);
    wait_done(0);
    tick();

    // ---- k=0: stop in OFFER, restart, reset in OFFER ----
    rdy[0] = 1'b0;
    pulse_start(0);
    wait_valid(0);
    sp[0] = 1'b1;
    tick();
    sp[0] = 1'b0;
    chk("stop valid", int'(vld[0]), 0);
    chk("stop busy", int'(bsy[0]), 0);
    chk("stop no done", int'(dn[0]), 0);
    pulse_start(0);
    wait_valid(0);
    chk_spawn("restart", 0, 0, 0, 0);
    tick();
    rst[0] = 1'b1; st[0] = 1'b1;
    tick();
    chk_reset_outs("rst offer", 0);
    tick();
    chk("rst offer hold busy", int'(bsy[0]), 0);
    rst[0] = 1'b0; st[0] = 1'b0;
    tick();
    chk("rst start ignored", int'(bsy[0]), 0);

    // ---- k=1: frame gap of 3, frames during OFFER not counted ----
    rdy[1] = 1'b0;
    pulse_start(1);
    wait_valid(1);
    chk_spawn("g id0", 1, 0, 0, 0);
    for (int p = 0; p < 2; p++) begin
      sof[1] = 1'b1; tick(); sof[1] = 1'b0; tick();
    end
    rdy[1] = 1'b1;
    tick();
    chk("g accept valid", int'(vld[1]), 0);
    for (int p = 1; p <= 3; p++) begin
      repeat (9) tick();
      chk($sformatf("g pre%0d valid", p), int'(vld[1]), 0);
      sof[1] = 1'b1;
      tick();
      sof[1] = 1'b0;
    end
    chk("g load valid", int'(vld[1]), 0);
    tick();
    chk_spawn("g id1", 1, 1, 2, 1);
    tick();
    sof[1] = 1'b1; tick(); sof[1] = 1'b0; tick();
    rst[1] = 1'b1; st[1] = 1'b1;
    tick();
    chk_reset_outs("rst gap", 1);
    tick();
    rst[1] = 1'b0; st[1] = 1'b0;
    tick();
    chk("rst gap start ignored", int'(bsy[1]), 0);
    pulse_start(1);
    wait_valid(1);
    chk_spawn("g restart", 1, 0, 0, 0);
    sp[1] = 1'b1; tick(); sp[1] = 1'b0;

    // ---- k=2: LOOP with 11-bit X wrap ----
    rdy[2] = 1'b1;
    pulse_start(2);
    for (int i = 0; i < 4; i++) begin
      wait_valid(2);
      chk_spawn($sformatf("loop%0d", i), 2, (i % 2) ? 1 : 2040, (i % 2) ? 2 : 0, i % 2);
    end
    sp[2] = 1'b1; tick(); sp[2] = 1'b0;
    chk("loop stop busy", int'(bsy[2]), 0);
    chk("loop stop done", int'(dn[2]), 0);
    sp[2] = 1'b1; st[2] = 1'b1;
    tick();
    sp[2] = 1'b0; st[2] = 1'b0;
    chk("stop beats start", int'(bsy[2]), 0);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/random_log_spawner.md
# random_log_spawner

Sequential consumer of the 100-entry static start-offset table. It walks the table one entry per spawn and converts each 9-bit X/Y offset into an absolute spawn position. Each position is offered to the log object manager over a valid/ready handshake, and consecutive spawns are spaced by a programmable number of video frames. It sits between the offset table and the log drawing/movement logic.

## Interface
- NUM_ENTRIES, 100, number of table entries walked (1..100)
- GAP_FRAMES, 8, startOfFrame pulses waited between an accepted spawn and the next load (0 = back-to-back)
- BASE_X, 11'd0, X origin added to every X offset
- BASE_Y, 11'd0, Y origin added to every Y offset
- LOOP, 1, 1 = wrap to entry 0 after the last entry; 0 = stop after the last entry
- CLK  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that begins a spawn sequence at entry 0
- stop  in  1  one-cycle pulse that aborts the sequence
- startOfFrame  in  1  one-cycle frame tick
- start_offsetX  in  9 x 100 (unpacked [99:0])  table X offsets
- start_offsetY  in  9 x 100 (unpacked [99:0])  table Y offsets
- spawn_ready  in  1  consumer accepts the current spawn
- spawn_valid  out  1  spawn_x/spawn_y/spawn_id are valid
- spawn_x  out  11  absolute X of the offered spawn
- spawn_y  out  11  absolute Y of the offered spawn
- spawn_id  out  7  table index of the offered spawn (0..NUM_ENTRIES-1)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the last entry is accepted with LOOP=0

## Operation
- States:
  - IDLE: busy=0. start moves to LOAD with idx=0.
  - LOAD: one cycle. Registers spawn_x = BASE_X + {2'b0, start_offsetX[idx]} mod 2048, spawn_y likewise, and spawn_id = idx. Moves to OFFER.
  - OFFER: spawn_valid=1. Outputs are held stable until spawn_valid & spawn_ready in the same cycle (handshake).
  - WAIT_GAP: counts startOfFrame pulses up to GAP_FRAMES, then moves to LOAD.
- Handshake in OFFER:
  - If idx == NUM_ENTRIES-1 and LOOP=0: pulse done and move to IDLE.
  - If idx == NUM_ENTRIES-1 and LOOP=1: idx wraps to 0.
  - Otherwise: idx increments.
  - In both non-terminal cases, move to WAIT_GAP, or directly to LOAD if GAP_FRAMES=0.
- Priority: reset > stop > everything else.
  - stop in any state moves to IDLE next cycle.
  - stop clears spawn_valid and the gap counter. No done pulse.
  - stop in the same cycle as a handshake: the handshake counts for the consumer, but no further spawn follows.
- start outside IDLE is ignored. start and stop together in IDLE: stop wins and the block stays IDLE.
- In WAIT_GAP, startOfFrame pulses during LOAD or OFFER are not counted. The gap counter restarts at 0 on every entry into WAIT_GAP.
- The offset inputs are sampled only in LOAD. Table changes at other times have no effect on the offered spawn.

## Timing
- Reset values: state=IDLE, idx=0, gap counter=0, spawn_valid=0, spawn_x=0, spawn_y=0, spawn_id=0, busy=0, done=0.
- start sampled high at cycle N (IDLE):
  - LOAD at N+1; busy=1 from N+1.
  - spawn_valid=1 with data from N+2.
- Handshake at cycle M: spawn_valid=0 at M+1.
  - GAP_FRAMES=0: LOAD at M+1 and spawn_valid=1 at M+2. Minimum one invalid cycle between spawns.
  - Otherwise: the G-th counted startOfFrame at cycle F gives LOAD at F+1 and spawn_valid at F+2.
- spawn_ready high while spawn_valid=0 has no effect.
- done is high in cycle M+1 only, in the same cycle busy returns to 0.
- stop at cycle S: spawn_valid=0 and busy=0 at S+1.
- Reset mid-operation: all outputs return to their reset values on the next edge. A pending spawn is dropped.

## Test plan
- Bench table offsetX[i]=i, offsetY[i]=2i; GAP_FRAMES=0, LOOP=0, NUM_ENTRIES=4, spawn_ready=1.
  - Pulse start.
  - Expect spawns (x,y,id) = (0,0,0), (1,2,1), (2,4,2), (3,6,3), each spawn_valid=1 for one cycle and separated by one invalid cycle.
  - Expect done one cycle after id 3, then IDLE.
- Backpressure: hold spawn_ready=0 for 5 cycles at id 1.
  - Expect spawn_valid and x=1, y=2, id=1 stable for all 5 cycles.
  - Expect exactly one acceptance when ready rises.
- GAP_FRAMES=3: after the id 0 handshake, pulse startOfFrame every 10 cycles.
  - Expect the id 1 spawn_valid exactly 2 cycles after the third pulse.
- LOOP=1, NUM_ENTRIES=2, BASE_X=2040, offsetX[1]=9.
  - Expect id sequence 0,1,0,1 with no done.
  - Expect x for id 1 equal to 1 (11-bit wrap).
- Pulse stop while in OFFER with spawn_ready=0, then pulse start.
  - Expect spawn_valid=0 and busy=0 next cycle.
  - Expect the restart at id 0.
- Assert reset in WAIT_GAP and in OFFER.
  - Expect all outputs at reset values next cycle.
  - Expect start ignored while reset is high.
